// File: rtl/lut3_sweep_ctrl.sv
// Purpose: exhaustive 8-code sweep of one LUT3 under test, checked against an expected truth table.
// Latency: REPEAT*8*(SETTLE_CYCLES+2) cycles from first DRIVE; done pulses on the following cycle.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next cycle.
// Optional capture of the sampled LUT outputs is enabled by defining LUT3_SWEEP_CAPTURE_EN.

module lut3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned REPEAT        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    output logic [2:0] lut_i,
    input  logic       lut_o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_idx,
    output logic [3:0] fail_cnt
`ifdef LUT3_SWEEP_CAPTURE_EN
    ,
    output logic [7:0] observed
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] SETTLE_LD  = 8'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_SWEEP = 4'(REPEAT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] exp_q;
    logic [2:0] idx_q;
    logic [3:0] sweep_q;
    logic [7:0] settle_q;

    logic       start_ok;
    logic       abort_run;
    logic       mismatch;
    logic       last_idx;
    logic       last_sweep;

    assign start_ok   = start && !abort;
    assign abort_run  = abort && (state_q != ST_IDLE);
    assign mismatch   = (lut_o != exp_q[idx_q]);
    assign last_idx   = (idx_q == 3'd7);
    assign last_sweep = (sweep_q == LAST_SWEEP);

    assign busy = (state_q != ST_IDLE);
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign done = (state_q == ST_DONE) && !abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort from any active state overrides the normal flow.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SETTLE;
            ST_SETTLE: if (settle_q == 8'd1) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (!last_idx || !last_sweep) state_d = ST_DRIVE;
                else                          state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_run) state_d = ST_IDLE;
    end

    // Datapath: truth-table latch, sweep counters, mismatch bookkeeping and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q    <= 8'h00;
            idx_q    <= 3'd0;
            sweep_q  <= 4'd0;
            settle_q <= 8'd0;
            lut_i    <= 3'd0;
            pass     <= 1'b0;
            fail_idx <= 3'd0;
            fail_cnt <= 4'd0;
`ifdef LUT3_SWEEP_CAPTURE_EN
            observed <= 8'h00;
`endif
        end else if (abort_run) begin
            // Partial counts and the driven code stay visible for debug.
            pass <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        exp_q    <= expected;
                        idx_q    <= 3'd0;
                        sweep_q  <= 4'd0;
                        pass     <= 1'b0;
                        fail_idx <= 3'd0;
                        fail_cnt <= 4'd0;
`ifdef LUT3_SWEEP_CAPTURE_EN
                        observed <= 8'h00;
`endif
                    end
                end
                ST_DRIVE: begin
                    lut_i    <= idx_q;
                    settle_q <= SETTLE_LD;
                end
                ST_SETTLE: begin
                    settle_q <= settle_q - 8'd1;
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        // fail_cnt still zero means this is the run's first mismatch.
                        if (fail_cnt == 4'd0) fail_idx <= idx_q;
                        if (fail_cnt != 4'hF) fail_cnt <= fail_cnt + 4'd1;
                    end
`ifdef LUT3_SWEEP_CAPTURE_EN
                    observed[idx_q] <= lut_o;
`endif
                    if (!last_idx) begin
                        idx_q <= idx_q + 3'd1;
                    end else if (!last_sweep) begin
                        idx_q   <= 3'd0;
                        sweep_q <= sweep_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    pass <= (fail_cnt == 4'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lut3_sweep_ctrl.sv
module tb_lut3_sweep_ctrl;

    logic       clk;
    logic       rst_n;

    logic       start_a, abort_a, lut_o_a, busy_a, done_a, pass_a;
    logic [7:0] exp_a, tbl_a;
    logic [2:0] lut_i_a, fail_idx_a;
    logic [3:0] fail_cnt_a;

    logic       start_b, abort_b, lut_o_b, busy_b, done_b, pass_b;
    logic [7:0] exp_b, tbl_b;
    logic [2:0] lut_i_b, fail_idx_b;
    logic [3:0] fail_cnt_b;

`ifdef LUT3_SWEEP_CAPTURE_EN
    logic [7:0] observed_a, observed_b;
`endif

    int total;
    int bad;

    assign lut_o_a = tbl_a[lut_i_a];
    assign lut_o_b = tbl_b[lut_i_b];

    lut3_sweep_ctrl #(.SETTLE_CYCLES(4), .REPEAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .expected(exp_a), .lut_i(lut_i_a), .lut_o(lut_o_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .fail_idx(fail_idx_a), .fail_cnt(fail_cnt_a)
`ifdef LUT3_SWEEP_CAPTURE_EN
        , .observed(observed_a)
`endif
    );

    lut3_sweep_ctrl #(.SETTLE_CYCLES(4), .REPEAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .expected(exp_b), .lut_i(lut_i_b), .lut_o(lut_o_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .fail_idx(fail_idx_b), .fail_cnt(fail_cnt_b)
`ifdef LUT3_SWEEP_CAPTURE_EN
        , .observed(observed_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with start_a already high; cycle 1 is the DRIVE cycle.
    task automatic wait_done_a(output int n);
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) start_a = 1'b0;
            if (done_a === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0) begin
            bad++; $display("FAIL reset_flags_a: got busy=%b done=%b pass=%b want 0 0 0", busy_a, done_a, pass_a);
        end
        total++; if (lut_i_a !== 3'd0 || fail_idx_a !== 3'd0 || fail_cnt_a !== 4'd0) begin
            bad++; $display("FAIL reset_vals_a: got lut_i=%0d idx=%0d cnt=%0d want 0 0 0", lut_i_a, fail_idx_a, fail_cnt_a);
        end
        total++; if (busy_b !== 1'b0 || fail_cnt_b !== 4'd0 || lut_i_b !== 3'd0) begin
            bad++; $display("FAIL reset_b: got busy=%b cnt=%0d lut_i=%0d want 0 0 0", busy_b, fail_cnt_b, lut_i_b);
        end
`ifdef LUT3_SWEEP_CAPTURE_EN
        total++; if (observed_a !== 8'h00) begin
            bad++; $display("FAIL reset_observed: got %h want 00", observed_a);
        end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pass_run();
        int n;
        tbl_a = 8'h83; exp_a = 8'h83; start_a = 1'b1;
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) start_a = 1'b0;
            if (n >= 2 && n <= 44 && ((n - 2) % 6) == 0) begin
                total++; if (lut_i_a !== 3'((n - 2) / 6)) begin
                    bad++; $display("FAIL pass_lut_i_step: got %0d want %0d at cycle %0d", lut_i_a, (n - 2) / 6, n);
                end
            end
            if (done_a === 1'b1) break;
        end
        total++; if (n != 49) begin
            bad++; $display("FAIL pass_done_latency: got %0d want 49", n);
        end
        total++; if (fail_cnt_a !== 4'd0 || fail_idx_a !== 3'd0) begin
            bad++; $display("FAIL pass_counts: got cnt=%0d idx=%0d want 0 0", fail_cnt_a, fail_idx_a);
        end
`ifdef LUT3_SWEEP_CAPTURE_EN
        total++; if (observed_a !== 8'h83) begin
            bad++; $display("FAIL pass_observed: got %h want 83", observed_a);
        end
`endif
        @(negedge clk);
        total++; if (pass_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            bad++; $display("FAIL pass_after_done: got pass=%b busy=%b done=%b want 1 0 0", pass_a, busy_a, done_a);
        end
    endtask

    task automatic test_single_mismatch();
        int n;
        @(negedge clk);
        tbl_a = 8'h83; exp_a = 8'h87; start_a = 1'b1;
        wait_done_a(n);
        total++; if (n != 49) begin
            bad++; $display("FAIL mism_done_latency: got %0d want 49", n);
        end
        total++; if (fail_cnt_a !== 4'd1 || fail_idx_a !== 3'd2) begin
            bad++; $display("FAIL mism_counts: got cnt=%0d idx=%0d want 1 2", fail_cnt_a, fail_idx_a);
        end
`ifdef LUT3_SWEEP_CAPTURE_EN
        total++; if (observed_a !== 8'h83) begin
            bad++; $display("FAIL mism_observed: got %h want 83", observed_a);
        end
`endif
        @(negedge clk);
        total++; if (pass_a !== 1'b0) begin
            bad++; $display("FAIL mism_pass: got %b want 0", pass_a);
        end
    endtask

    task automatic test_repeat_saturate();
        int n;
        @(negedge clk);
        tbl_b = 8'h00; exp_b = 8'hFF; start_b = 1'b1;
        for (n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (n == 1) start_b = 1'b0;
            if (done_b === 1'b1) break;
        end
        total++; if (n != 145) begin
            bad++; $display("FAIL rep_done_latency: got %0d want 145", n);
        end
        total++; if (fail_cnt_b !== 4'd15 || fail_idx_b !== 3'd0) begin
            bad++; $display("FAIL rep_counts: got cnt=%0d idx=%0d want 15 0", fail_cnt_b, fail_idx_b);
        end
`ifdef LUT3_SWEEP_CAPTURE_EN
        total++; if (observed_b !== 8'h00) begin
            bad++; $display("FAIL rep_observed: got %h want 00", observed_b);
        end
`endif
        @(negedge clk);
        total++; if (pass_b !== 1'b0 || busy_b !== 1'b0) begin
            bad++; $display("FAIL rep_after_done: got pass=%b busy=%b want 0 0", pass_b, busy_b);
        end
    endtask

    task automatic test_abort();
        int dones;
        @(negedge clk);
        tbl_a = 8'h83; exp_a = 8'h81; start_a = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            if (n == 1) start_a = 1'b0;
        end
        total++; if (busy_a !== 1'b1 || lut_i_a !== 3'd4) begin
            bad++; $display("FAIL abort_pre: got busy=%b lut_i=%0d want 1 4", busy_a, lut_i_a);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        total++; if (busy_a !== 1'b0 || pass_a !== 1'b0) begin
            bad++; $display("FAIL abort_idle: got busy=%b pass=%b want 0 0", busy_a, pass_a);
        end
        total++; if (fail_cnt_a !== 4'd1 || fail_idx_a !== 3'd1 || lut_i_a !== 3'd4) begin
            bad++; $display("FAIL abort_partial: got cnt=%0d idx=%0d lut_i=%0d want 1 1 4", fail_cnt_a, fail_idx_a, lut_i_a);
        end
        dones = 0;
        for (int n = 0; n < 60; n++) begin
            if (done_a === 1'b1 || busy_a !== 1'b0) dones++;
            @(negedge clk);
        end
        total++; if (dones != 0) begin
            bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
        end
    endtask

    task automatic test_ignored_start();
        int n;
        int stray;
        @(negedge clk);
        tbl_a = 8'h83; exp_a = 8'h83; start_a = 1'b1;
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            start_a = (n == 10);
            exp_a   = 8'h00;
            if (done_a === 1'b1) break;
        end
        start_a = 1'b0;
        total++; if (n != 49) begin
            bad++; $display("FAIL busy_start_latency: got %0d want 49", n);
        end
        total++; if (fail_cnt_a !== 4'd0) begin
            bad++; $display("FAIL busy_start_cnt: got %0d want 0", fail_cnt_a);
        end
        @(negedge clk);
        total++; if (pass_a !== 1'b1) begin
            bad++; $display("FAIL busy_start_pass: got %b want 1", pass_a);
        end
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy_a !== 1'b0 || done_a !== 1'b0) stray++;
            @(negedge clk);
        end
        total++; if (stray != 0 || pass_a !== 1'b1) begin
            bad++; $display("FAIL start_abort_idle: got stray=%0d pass=%b want 0 1", stray, pass_a);
        end
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        tbl_a = 8'h83; exp_a = 8'h00; start_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) start_a = 1'b0;
        end
        total++; if (lut_i_a !== 3'd1 || fail_cnt_a !== 4'd1 || busy_a !== 1'b1) begin
            bad++; $display("FAIL arst_pre: got lut_i=%0d cnt=%0d busy=%b want 1 1 1", lut_i_a, fail_cnt_a, busy_a);
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy_a !== 1'b0 || lut_i_a !== 3'd0 || fail_cnt_a !== 4'd0 || fail_idx_a !== 3'd0 || pass_a !== 1'b0 || done_a !== 1'b0) begin
            bad++; $display("FAIL arst_clear: got busy=%b lut_i=%0d cnt=%0d idx=%0d pass=%b done=%b want all 0",
                            busy_a, lut_i_a, fail_cnt_a, fail_idx_a, pass_a, done_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_a = 8'h83; start_a = 1'b1;
        wait_done_a(n);
        total++; if (n != 49 || fail_cnt_a !== 4'd0) begin
            bad++; $display("FAIL arst_rerun: got latency=%0d cnt=%0d want 49 0", n, fail_cnt_a);
        end
        @(negedge clk);
        total++; if (pass_a !== 1'b1) begin
            bad++; $display("FAIL arst_rerun_pass: got %b want 1", pass_a);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; exp_a = 8'h00; tbl_a = 8'h00;
        start_b = 1'b0; abort_b = 1'b0; exp_b = 8'h00; tbl_b = 8'h00;
        test_reset();
        test_pass_run();
        test_single_mismatch();
        test_repeat_saturate();
        test_abort();
        test_ignored_start();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
